// File: rtl/uart_byte_bridge.sv
// Byte FIFO bridge from a UART receiver to a transmitter, with a per-byte send timeout.
// Optional build macro UART_BRIDGE_DIGIT_FILTER_EN: accept only ASCII '0'..'9'.
module uart_byte_bridge #(
    parameter int DEPTH          = 8,
    parameter int TIMEOUT_CYCLES = 2500000
) (
    input  logic                     hwclk,
    input  logic                     rst_n,
    input  logic                     rx_dv,
    input  logic [7:0]               rx_byte,
    input  logic                     tx_done,
    input  logic                     clr_err,
    output logic [7:0]               tx_byte,
    output logic                     tx_send,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow,
    output logic                     tx_timeout,
    output logic                     busy
);

    localparam int          PTR_W   = $clog2(DEPTH);
    localparam int          CNT_W   = PTR_W + 1;
    localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SEND, WAIT_DONE} state_t;

    state_t             state;
    logic [7:0]         mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               td_meta;
    logic               tds;
    logic [31:0]        to_cnt;

    logic               accept;
    logic               full;
    logic               pop;
    logic               push;
    logic               ovf_set;
    logic               to_fire;

`ifdef UART_BRIDGE_DIGIT_FILTER_EN
    assign accept = rx_dv && (rx_byte >= 8'd48) && (rx_byte <= 8'd57);
`else
    assign accept = rx_dv;
`endif

    assign full    = (fifo_count == CNT_W'(DEPTH));
    assign pop     = (state == IDLE) && (fifo_count != '0) && tds;
    // A pop in the same cycle frees the slot, so a full FIFO still takes the byte.
    assign push    = accept && (!full || pop);
    assign ovf_set = accept && full && !pop;
    assign to_fire = (state == SEND) && tds && (to_cnt >= TO_LAST);
    assign busy    = (state != IDLE) || (fifo_count != '0);

    // tx_done comes from the baud-clock domain; idle level is high.
    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            td_meta <= 1'b1;
            tds     <= 1'b1;
        end else begin
            td_meta <= tx_done;
            tds     <= td_meta;
        end
    end

    always_ff @(posedge hwclk) begin
        if (push) begin
            mem[wr_ptr] <= rx_byte;
        end
    end

    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                fifo_count <= fifo_count + CNT_W'(1);
            end else if (pop && !push) begin
                fifo_count <= fifo_count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            tx_send <= 1'b0;
            tx_byte <= 8'h00;
            to_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        tx_byte <= mem[rd_ptr];
                        tx_send <= 1'b1;
                        to_cnt  <= '0;
                        state   <= SEND;
                    end
                end
                SEND: begin
                    if (!tds) begin
                        tx_send <= 1'b0;
                        state   <= WAIT_DONE;
                    end else if (to_fire) begin
                        tx_send <= 1'b0;
                        state   <= IDLE;
                    end else if (to_cnt != '1) begin
                        to_cnt <= to_cnt + 32'd1;
                    end
                end
                WAIT_DONE: begin
                    if (tds) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    tx_send <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    // Sticky flags: a set in the same cycle as clr_err takes priority.
    always_ff @(posedge hwclk or negedge rst_n) begin
        if (!rst_n) begin
            overflow   <= 1'b0;
            tx_timeout <= 1'b0;
        end else begin
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end
            if (to_fire) begin
                tx_timeout <= 1'b1;
            end else if (clr_err) begin
                tx_timeout <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_byte_bridge.sv
// Scoreboard bench for uart_byte_bridge: directed bytes queue expectations, a monitor checks each send.
module tb_uart_byte_bridge;

    logic       hwclk = 1'b0;
    logic       rst_n;
    logic       rx_dv;
    logic [7:0] rx_byte;
    logic       tx_done;
    logic       clr_err;
    logic [7:0] tx_byte;
    logic       tx_send;
    logic [3:0] fifo_count;
    logic       overflow;
    logic       tx_timeout;
    logic       busy;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_q[$];
    logic       prev_send = 1'b0;

    always #5 hwclk = ~hwclk;

    uart_byte_bridge #(.DEPTH(8), .TIMEOUT_CYCLES(100)) dut (
        .hwclk      (hwclk),
        .rst_n      (rst_n),
        .rx_dv      (rx_dv),
        .rx_byte    (rx_byte),
        .tx_done    (tx_done),
        .clr_err    (clr_err),
        .tx_byte    (tx_byte),
        .tx_send    (tx_send),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .tx_timeout (tx_timeout),
        .busy       (busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every rising tx_send must present the next queued byte.
    always @(negedge hwclk) begin
        if (rst_n && tx_send && !prev_send) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL tx_unexpected: got byte %0h, expected no send", tx_byte);
            end else begin
                check("tx_byte", {24'd0, tx_byte}, {24'd0, exp_q.pop_front()});
            end
        end
        prev_send = tx_send;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge hwclk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit expect_tx);
        rx_dv   = 1'b1;
        rx_byte = b;
        if (expect_tx) exp_q.push_back(b);
        @(negedge hwclk);
        rx_dv = 1'b0;
    endtask

    task automatic wait_send(input logic lvl, input string name);
        int k = 0;
        while (tx_send !== lvl && k < 500) begin
            @(negedge hwclk);
            k++;
        end
        check(name, {31'd0, tx_send}, {31'd0, lvl});
    endtask

    task automatic handshake();
        wait_send(1'b1, "hs_send_hi");
        tx_done = 1'b0;
        wait_send(1'b0, "hs_send_lo");
        tx_done = 1'b1;
        tick(3);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish before 1ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hi;
        int g;
        rst_n   = 1'b0;
        rx_dv   = 1'b0;
        rx_byte = 8'h00;
        tx_done = 1'b1;
        clr_err = 1'b0;
        tick(3);
        check("rst_count", {28'd0, fifo_count}, 32'd0);
        check("rst_send", {31'd0, tx_send}, 32'd0);
        check("rst_byte", {24'd0, tx_byte}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        check("rst_to", {31'd0, tx_timeout}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        tick(2);

        // Single byte with full handshake
        send_byte(8'h30, 1'b1);
        check("single_count", {28'd0, fifo_count}, 32'd1);
        check("single_send_early", {31'd0, tx_send}, 32'd0);
        tick(1);
        check("single_send", {31'd0, tx_send}, 32'd1);
        check("single_txbyte", {24'd0, tx_byte}, 32'h30);
        tx_done = 1'b0;
        tick(3);
        check("wait_send_low", {31'd0, tx_send}, 32'd0);
        check("wait_busy", {31'd0, busy}, 32'd1);
        check("wait_txbyte", {24'd0, tx_byte}, 32'h30);
        tx_done = 1'b1;
        tick(3);
        check("single_idle_busy", {31'd0, busy}, 32'd0);

        // Burst with the transmitter never acknowledging
        for (int i = 0; i < 9; i++) send_byte(8'h31 + 8'(i), 1'b1);
        check("burst_count", {28'd0, fifo_count}, 32'd8);
        check("burst_ovf0", {31'd0, overflow}, 32'd0);
        send_byte(8'h30, 1'b0);
        check("burst_ovf1", {31'd0, overflow}, 32'd1);
        check("burst_count_full", {28'd0, fifo_count}, 32'd8);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        check("clr_ovf", {31'd0, overflow}, 32'd0);
        check("burst_to0", {31'd0, tx_timeout}, 32'd0);

        // First byte times out; push lands on the same edge as the next pop
        wait_send(1'b0, "timeout_fall");
        check("timeout_flag", {31'd0, tx_timeout}, 32'd1);
        check("timeout_count", {28'd0, fifo_count}, 32'd8);
        send_byte(8'h37, 1'b1);
        check("fullpop_count", {28'd0, fifo_count}, 32'd8);
        check("fullpop_send", {31'd0, tx_send}, 32'd1);
        check("fullpop_ovf", {31'd0, overflow}, 32'd0);
        hi = 1;
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        if (tx_send) hi++;
        check("clr_to", {31'd0, tx_timeout}, 32'd0);
        g = 0;
        while (tx_send && g < 300) begin
            tick(1);
            g++;
            if (tx_send) hi++;
        end
        check("timeout_len", hi, 32'd100);
        check("timeout_flag2", {31'd0, tx_timeout}, 32'd1);

        for (int i = 0; i < 8; i++) handshake();
        check("drain_count", {28'd0, fifo_count}, 32'd0);
        check("drain_busy", {31'd0, busy}, 32'd0);

        // Reset during SEND with three bytes queued
        send_byte(8'h32, 1'b1);
        send_byte(8'h33, 1'b0);
        send_byte(8'h34, 1'b0);
        send_byte(8'h35, 1'b0);
        check("pre_rst_count", {28'd0, fifo_count}, 32'd3);
        check("pre_rst_send", {31'd0, tx_send}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_send", {31'd0, tx_send}, 32'd0);
        check("async_rst_count", {28'd0, fifo_count}, 32'd0);
        check("async_rst_busy", {31'd0, busy}, 32'd0);
        check("async_rst_byte", {24'd0, tx_byte}, 32'd0);
        @(negedge hwclk);
        rst_n = 1'b1;
        send_byte(8'h34, 1'b1);
        handshake();
        check("post_rst_busy", {31'd0, busy}, 32'd0);

        // Non-digit followed by a digit
`ifdef UART_BRIDGE_DIGIT_FILTER_EN
        send_byte(8'h41, 1'b0);
        send_byte(8'h35, 1'b1);
        handshake();
`else
        send_byte(8'h41, 1'b1);
        send_byte(8'h35, 1'b1);
        handshake();
        handshake();
`endif
        check("filter_ovf", {31'd0, overflow}, 32'd0);
        check("filter_busy", {31'd0, busy}, 32'd0);
        check("queue_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_byte_bridge.md
UART_BYTE_BRIDGE -- requirements
Module: uart_byte_bridge

Interface
REQ-001 Parameter DEPTH, default 8, sets FIFO depth in bytes; it SHALL be a power of two, 2..64.
REQ-002 Parameter TIMEOUT_CYCLES, default 2500000, sets the hwclk cycles allowed for tx_done to fall after tx_send rises.
REQ-003 hwclk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 rx_dv  in  1  one-hwclk pulse from the UART receiver; rx_byte is valid in that cycle.
REQ-006 rx_byte  in  8  received byte.
REQ-007 tx_done  in  1  transmitter idle level, high when idle, from the baud-clock domain.
REQ-008 clr_err  in  1  synchronous clear of the sticky error flags.
REQ-009 tx_byte  out  8  byte presented to the transmitter.
REQ-010 tx_send  out  1  transmit request level.
REQ-011 fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-012 overflow  out  1  sticky flag: a byte was dropped because the FIFO was full.
REQ-013 tx_timeout  out  1  sticky flag: a byte was abandoned on timeout.
REQ-014 busy  out  1  high whenever the state is not IDLE or fifo_count is not 0.

Function
REQ-015 The block SHALL pass tx_done through a 2-flop synchronizer; all FSM decisions SHALL use the synchronized value, tds.
REQ-016 On rx_dv, the block SHALL write rx_byte at the write pointer and increment fifo_count, unless the FIFO is full.
REQ-017 On rx_dv with the FIFO full and no pop in the same cycle, the block SHALL drop the byte, set overflow, and leave the FIFO unchanged.
REQ-018 On push and pop in the same cycle, fifo_count SHALL be unchanged and both operations SHALL succeed, including when the FIFO is full.
REQ-019 The pointers SHALL be $clog2(DEPTH) bits wide and SHALL wrap from DEPTH-1 to 0.
REQ-020 The FSM SHALL have three states: IDLE, SEND and WAIT_DONE.
REQ-021 IDLE: if fifo_count!=0 and tds==1, the block SHALL pop the head byte into the tx_byte register, set tx_send=1 and go to SEND.
REQ-022 SEND: tx_send SHALL be held at 1; when tds==0, the block SHALL clear tx_send and go to WAIT_DONE.
REQ-023 SEND: if TIMEOUT_CYCLES elapse with tds==1, the block SHALL clear tx_send, set tx_timeout, discard the byte and go to IDLE.
REQ-024 WAIT_DONE: when tds==1, the block SHALL go to IDLE; this state SHALL have no timeout.
REQ-025 tx_byte SHALL remain stable from the entry into SEND until the exit from WAIT_DONE.
REQ-026 Latency: rx_dv at edge N into an empty FIFO, with tds==1, SHALL give tx_send=1 after edge N+1.
REQ-027 The timeout counter SHALL be 32 bits, SHALL clear on entry to SEND and SHALL saturate.
REQ-028 clr_err SHALL clear overflow and tx_timeout; if set and clear coincide, set SHALL win.

Reset
REQ-029 rst_n low SHALL immediately force: state=IDLE, pointers=0, fifo_count=0, tx_send=0, tx_byte=8'h00, overflow=0, tx_timeout=0, busy=0, synchronizer flops=1.
REQ-030 A reset asserted mid-transfer SHALL drop tx_send asynchronously and discard all FIFO contents.
REQ-031 The block SHALL leave reset synchronously; the first rx_dv after rst_n rises SHALL be accepted.

Configuration
REQ-032 With UART_BRIDGE_DIGIT_FILTER_EN defined, only bytes 8'd48..8'd57 (ASCII '0'..'9') SHALL be written to the FIFO.
REQ-033 With UART_BRIDGE_DIGIT_FILTER_EN defined, all other bytes SHALL be silently discarded without setting overflow.
REQ-034 With UART_BRIDGE_DIGIT_FILTER_EN undefined, every byte SHALL be accepted and no filter logic SHALL be present.

Verification
REQ-035 Single byte: rx_dv with 8'h30, tx_done=1 -> tx_send=1 after 2 edges, tx_byte=8'h30; drop tx_done -> WAIT_DONE; raise tx_done -> IDLE, busy=0.
REQ-036 Burst: 8 bytes 8'h31..8'h38 back-to-back with tx_done stuck at 1 (no handshake), then a 9th byte 8'h39 -> fifo_count=8 (1 byte held in tx_byte, 7 queued plus the 9th), overflow=0; 10th byte -> overflow=1, fifo_count=8; clr_err -> overflow=0.
REQ-037 Full with pop: FIFO full, rx_dv in the same cycle as an IDLE->SEND pop -> fifo_count stays at DEPTH and the new byte is stored last.
REQ-038 Timeout: TIMEOUT_CYCLES=100, tx_done held at 1 -> tx_send falls and tx_timeout=1 after 100 cycles in SEND; the next byte is then sent normally.
REQ-039 Reset mid-transfer: rst_n low during SEND with 3 bytes queued -> tx_send=0 and fifo_count=0 without a clock edge.
REQ-040 Filter: with UART_BRIDGE_DIGIT_FILTER_EN, send 8'h41, 8'h35 -> only 8'h35 is transmitted; without the macro, both are transmitted.
